sw_event_reader: RTL and testbench
==================================

SW_EVENT_READER -- requirements
Module: sw_event_reader

Interface
REQ-001 Parameter MASK, default 10'h3FF, irq_mask value written to the PIO at start-up.
REQ-002 Parameter DEPTH, default 8, event FIFO depth; power of 2, range 2..64.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  when high, new IRQ service sequences may start.
REQ-006 address  out  2  Avalon-MM word address to the PIO.
REQ-007 chipselect  out  1  PIO select; high only during write cycles.
REQ-008 write_n  out  1  active-low write strobe.
REQ-009 writedata  out  32  write data; bits 31:10 always 0.
REQ-010 readdata  in  32  PIO read data; only bits 9:0 used.
REQ-011 irq  in  1  PIO interrupt, synchronous to clk.
REQ-012 evt_valid  out  1  FIFO head event valid.
REQ-013 evt_ready  in  1  consumer accepts head when evt_valid && evt_ready.
REQ-014 evt_capture  out  10  captured edge bits of head event.
REQ-015 evt_data  out  10  switch levels of head event.

Function
REQ-016 All master outputs SHALL be registered; read latency SHALL be exactly 1: address held in cycle N, readdata sampled at the end of cycle N+1.
REQ-017 A write SHALL be one cycle, chipselect=1 and write_n=0, with no wait states.
REQ-018 FSM states: INIT, WAIT_IRQ, CAP_ADDR, CAP_SMP, CLR, DAT_ADDR, DAT_SMP, PUSH.
REQ-019 INIT: write MASK to address 2 for one cycle, then go to WAIT_IRQ.
REQ-020 WAIT_IRQ: on irq && enable, go to CAP_ADDR; otherwise remain.
REQ-021 CAP_ADDR: drive address 3. CAP_SMP: latch readdata[9:0] into cap.
REQ-022 After CAP_SMP, if cap==0, return to WAIT_IRQ with no write and no push (spurious IRQ).
REQ-023 CLR: write cap to address 3, clearing only the bits that were read; edges on other bits SHALL survive.
REQ-024 DAT_ADDR: drive address 0. DAT_SMP: latch readdata[9:0] into dat.
REQ-025 PUSH: enqueue {cap,dat}, then go to WAIT_IRQ.
REQ-026 With irq high in WAIT_IRQ at cycle T, the event SHALL be written at the end of T+6 and evt_valid SHALL be high in T+7 when the FIFO was empty.
REQ-027 The FIFO SHALL be first-word fall-through; pop on evt_valid && evt_ready.
REQ-028 Push and pop in the same cycle SHALL both succeed when the FIFO is full or empty-with-push.
REQ-029 Pointers SHALL wrap modulo DEPTH; an extra wrap bit SHALL distinguish full from empty.
REQ-030 Deasserting enable mid-sequence SHALL NOT abort it; only new starts are blocked.
REQ-031 An edge on a bit in the same cycle as its CLR write is lost; this is the PIO's clear-priority behaviour and is accepted.

Reset
REQ-032 On reset assertion, immediately: chipselect=0, write_n=1, address=0, writedata=0, evt_valid=0, FIFO empty, cap=dat=0, state=INIT.
REQ-033 On reset release, INIT SHALL execute in the first clock cycle.
REQ-034 Reset during any state SHALL abandon the sequence; no partial event is pushed.

Configuration
REQ-035 Macro SW_EVT_OVF_CNT_EN defined: PUSH on a full FIFO drops the event, increments a saturating 8-bit output ovf_count (reset 0), and continues to WAIT_IRQ.
REQ-036 Macro SW_EVT_OVF_CNT_EN undefined: PUSH on a full FIFO stalls in PUSH until space exists; no ovf_count port exists.

Verification
REQ-037 Reset release -> one write cycle at address 2 with writedata 0x3FF; then idle, chipselect=0.
REQ-038 irq=1 at T, readdata=0x004 at T+2, 0x2A5 at T+5 -> write 0x004 to address 3 at T+3; evt_valid at T+7 with capture=0x004, data=0x2A5.
REQ-039 irq=1 with readdata=0 in CAP_SMP -> no write, no event, return to WAIT_IRQ.
REQ-040 evt_ready=0 and DEPTH+1 IRQs -> first DEPTH events held in order. With the macro: ovf_count=1. Without it: FSM waits in PUSH until one pop, then pushes the ninth event.
REQ-041 Reset asserted during DAT_SMP -> outputs return to reset values asynchronously; FIFO empty; INIT write repeats after release.
REQ-042 enable=0 with irq=1 -> no bus activity; enable rises -> sequence starts the next cycle.

Source files
------------

// File: rtl/sw_event_reader.sv
// Switch-PIO event reader: services PIO edge IRQs and queues {capture,data}.
// Optional SW_EVT_OVF_CNT_EN: drop on full FIFO and count drops in ovf_count.
module sw_event_reader #(
  parameter logic [9:0] MASK  = 10'h3FF,
  parameter int         DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        irq,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [9:0]  evt_capture,
  output logic [9:0]  evt_data
`ifdef SW_EVT_OVF_CNT_EN
  ,
  output logic [7:0]  ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    INIT, WAIT_IRQ, CAP_ADDR, CAP_SMP,
    CLR, DAT_ADDR, DAT_SMP, PUSH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_addr;
  logic        r_cs;
  logic [9:0]  r_wdata;
  logic [9:0]  r_cap;
  logic [9:0]  r_dat;
  logic [1:0]  w_addr_d;
  logic        w_cs_d;
  logic [9:0]  w_wdata_d;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [19:0] r_mem [DEPTH];
  logic        w_unused;

  assign w_unused = ^readdata[31:10];

  assign address    = r_addr;
  assign chipselect = r_cs;
  assign write_n    = ~r_cs;
  assign writedata  = {22'd0, r_wdata};

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = evt_valid && evt_ready;

  assign evt_valid   = ~w_empty;
  assign evt_capture = r_mem[r_rptr[AW-1:0]][19:10];
  assign evt_data    = r_mem[r_rptr[AW-1:0]][9:0];

`ifdef SW_EVT_OVF_CNT_EN
  logic       w_drop;
  logic [7:0] r_ovf;
  assign ovf_count = r_ovf;
`endif

  // Bus outputs are computed for the cycle after the edge, then registered.
  always_comb begin
    w_next    = r_state;
    w_addr_d  = 2'd0;
    w_cs_d    = 1'b0;
    w_wdata_d = 10'd0;
    w_push    = 1'b0;
`ifdef SW_EVT_OVF_CNT_EN
    w_drop    = 1'b0;
`endif
    unique case (r_state)
      INIT: begin
        w_next    = WAIT_IRQ;
        w_cs_d    = 1'b1;
        w_addr_d  = 2'd2;
        w_wdata_d = MASK;
      end
      WAIT_IRQ: begin
        if (irq && enable) begin
          w_next   = CAP_ADDR;
          w_addr_d = 2'd3;
        end
      end
      CAP_ADDR: begin
        w_next   = CAP_SMP;
        w_addr_d = 2'd3;
      end
      CAP_SMP: begin
        if (readdata[9:0] == 10'd0) begin
          w_next = WAIT_IRQ;
        end else begin
          w_next    = CLR;
          w_cs_d    = 1'b1;
          w_addr_d  = 2'd3;
          w_wdata_d = readdata[9:0];
        end
      end
      CLR:      w_next = DAT_ADDR;
      DAT_ADDR: w_next = DAT_SMP;
      DAT_SMP:  w_next = PUSH;
      PUSH: begin
        if (!w_full || w_pop) begin
          w_push = 1'b1;
          w_next = WAIT_IRQ;
        end else begin
`ifdef SW_EVT_OVF_CNT_EN
          w_drop = 1'b1;
          w_next = WAIT_IRQ;
`else
          w_next = PUSH;
`endif
        end
      end
      default: w_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_addr  <= 2'd0;
      r_cs    <= 1'b0;
      r_wdata <= 10'd0;
      r_cap   <= 10'd0;
      r_dat   <= 10'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_d;
      r_cs    <= w_cs_d;
      r_wdata <= w_wdata_d;
      if (r_state == CAP_SMP) r_cap <= readdata[9:0];
      if (r_state == DAT_SMP) r_dat <= readdata[9:0];
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {r_cap, r_dat};
  end

`ifdef SW_EVT_OVF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 8'd0;
    end else if (w_drop && r_ovf != 8'hFF) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sw_event_reader.sv
// Directed bench for sw_event_reader: bus timing, FIFO order, reset.
// Honours SW_EVT_OVF_CNT_EN for the full-FIFO scenario.
module tb_sw_event_reader;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata = 32'd0;
  logic        irq = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [9:0]  evt_capture;
  logic [9:0]  evt_data;
`ifdef SW_EVT_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  int vec = 0;
  int errs = 0;

  sw_event_reader #(.MASK(10'h3FF), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_capture(evt_capture),
    .evt_data(evt_data)
`ifdef SW_EVT_OVF_CNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one IRQ service; returns in the PUSH cycle (T+6).
  task automatic service(input logic [9:0] c, input logic [9:0] d);
    step(); irq = 1'b1;
    step(); irq = 1'b0;
    step(); readdata = 32'hFFFF_FC00 | {22'd0, c};
    step(); readdata = 32'd0;
    step();
    step(); readdata = {22'd0, d};
    step(); readdata = 32'd0;
  endtask

  task automatic test_reset();
    step();
    vec++; if (chipselect !== 1'b0) begin errs++; $display("FAIL rst_cs got %0h exp 0", chipselect); end
    vec++; if (write_n !== 1'b1) begin errs++; $display("FAIL rst_wn got %0h exp 1", write_n); end
    vec++; if (address !== 2'd0 || writedata !== 32'd0) begin errs++; $display("FAIL rst_bus got a=%0h d=%0h exp 0/0", address, writedata); end
    vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0h exp 0", evt_valid); end
    @(negedge clk); reset = 1'b0;
    step();
    vec++; if (chipselect !== 1'b1 || write_n !== 1'b0) begin errs++; $display("FAIL init_wr got cs=%0h wn=%0h exp 1/0", chipselect, write_n); end
    vec++; if (address !== 2'd2 || writedata !== 32'h3FF) begin errs++; $display("FAIL init_data got a=%0h d=%0h exp 2/3ff", address, writedata); end
    step();
    vec++; if (chipselect !== 1'b0 || write_n !== 1'b1) begin errs++; $display("FAIL init_idle got cs=%0h wn=%0h exp 0/1", chipselect, write_n); end
  endtask

  task automatic test_event();
    step(); irq = 1'b1;
    step(); irq = 1'b0; enable = 1'b0;
    vec++; if (address !== 2'd3 || chipselect !== 1'b0) begin errs++; $display("FAIL cap_addr got a=%0h cs=%0h exp 3/0", address, chipselect); end
    step(); readdata = 32'h0000_0004;
    step(); readdata = 32'd0;
    vec++; if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== 2'd3) begin errs++; $display("FAIL clr_wr got cs=%0h wn=%0h a=%0h exp 1/0/3", chipselect, write_n, address); end
    vec++; if (writedata !== 32'h004) begin errs++; $display("FAIL clr_data got %0h exp 4", writedata); end
    step();
    vec++; if (address !== 2'd0 || chipselect !== 1'b0) begin errs++; $display("FAIL dat_addr got a=%0h cs=%0h exp 0/0", address, chipselect); end
    step(); readdata = 32'h0000_02A5;
    step(); readdata = 32'd0;
    vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL early_valid got %0h exp 0", evt_valid); end
    step();
    vec++; if (evt_valid !== 1'b1) begin errs++; $display("FAIL evt_valid got %0h exp 1", evt_valid); end
    vec++; if (evt_capture !== 10'h004 || evt_data !== 10'h2A5) begin errs++; $display("FAIL evt_head got c=%0h d=%0h exp 4/2a5", evt_capture, evt_data); end
    enable = 1'b1; evt_ready = 1'b1;
    step(); evt_ready = 1'b0;
    vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL evt_pop got %0h exp 0", evt_valid); end
  endtask

  task automatic test_spurious();
    step(); irq = 1'b1;
    step(); irq = 1'b0;
    step(); readdata = 32'hFFFF_FC00;
    step(); readdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      vec++; if (chipselect !== 1'b0 || evt_valid !== 1'b0) begin errs++; $display("FAIL spur_%0d got cs=%0h v=%0h exp 0/0", i, chipselect, evt_valid); end
      step();
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vec++; if (chipselect !== 1'b0 || address !== 2'd0) begin errs++; $display("FAIL en_block_%0d got cs=%0h a=%0h exp 0/0", i, chipselect, address); end
    end
    enable = 1'b1;
    step(); irq = 1'b0;
    vec++; if (address !== 2'd3) begin errs++; $display("FAIL en_start got a=%0h exp 3", address); end
    step(); readdata = 32'd0;
    step();
  endtask

  task automatic test_fill();
    evt_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      service(10'(i + 1), 10'(10'h100 + i));
    end
    repeat (3) step();
    vec++; if (evt_valid !== 1'b1 || evt_capture !== 10'd1) begin errs++; $display("FAIL fill_head got v=%0h c=%0h exp 1/1", evt_valid, evt_capture); end
`ifdef SW_EVT_OVF_CNT_EN
    vec++; if (ovf_count !== 8'd1) begin errs++; $display("FAIL ovf_cnt got %0d exp 1", ovf_count); end
`endif
    evt_ready = 1'b1;
`ifdef SW_EVT_OVF_CNT_EN
    for (int i = 0; i < DEPTH; i++) begin
`else
    for (int i = 0; i <= DEPTH; i++) begin
`endif
      vec++; if (evt_valid !== 1'b1 || evt_capture !== 10'(i + 1) || evt_data !== 10'(10'h100 + i)) begin
        errs++; $display("FAIL fill_ord_%0d got v=%0h c=%0h d=%0h exp 1/%0h/%0h", i, evt_valid, evt_capture, evt_data, i + 1, 10'h100 + i);
      end
      step();
    end
    evt_ready = 1'b0;
    vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL fill_drain got %0h exp 0", evt_valid); end
  endtask

  task automatic test_reset_mid();
    service(10'h010, 10'h055);
    step(); irq = 1'b1;
    vec++; if (evt_valid !== 1'b1) begin errs++; $display("FAIL rm_pre got %0h exp 1", evt_valid); end
    step(); irq = 1'b0;
    step(); readdata = 32'h0000_0020;
    step(); readdata = 32'd0;
    step();
    step(); readdata = 32'h0000_0066;
    #2 reset = 1'b1;
    #1;
    vec++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL rm_valid got %0h exp 0", evt_valid); end
    vec++; if (chipselect !== 1'b0 || write_n !== 1'b1 || address !== 2'd0 || writedata !== 32'd0) begin
      errs++; $display("FAIL rm_bus got cs=%0h wn=%0h a=%0h d=%0h exp 0/1/0/0", chipselect, write_n, address, writedata);
    end
    @(negedge clk); reset = 1'b0; readdata = 32'd0;
    step();
    vec++; if (chipselect !== 1'b1 || address !== 2'd2 || writedata !== 32'h3FF) begin
      errs++; $display("FAIL rm_init got cs=%0h a=%0h d=%0h exp 1/2/3ff", chipselect, address, writedata);
    end
    repeat (8) step();
    vec++; if (evt_valid !== 1'b0 || chipselect !== 1'b0) begin errs++; $display("FAIL rm_nopush got v=%0h cs=%0h exp 0/0", evt_valid, chipselect); end
  endtask

  initial begin
    test_reset();
    test_event();
    test_spurious();
    test_enable();
    test_fill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
